spi_debug_ctrl: RTL and testbench
=================================

// Module: spi_debug_ctrl
// PURPOSE
//  Byte-stream debug command processor between spi_slave (recv_data/recv_ready -> send_data) and the core.
//  Generalises the top-level debug handler:
//   - N selectable read channels of parametrised width
//   - counted multi-cycle clock stepping
//   - length-prefixed replies
//  Outputs a registered core clock enable; the clock gate itself sits outside this block.
// PARAMETERS
//  NUM_REGS   4   number of readable debug channels (1..256); ch0 = pc, ch1 = fetched instruction, rest free
//  REG_WIDTH  64  bits per channel; multiple of 8, 8..64; reply length L = REG_WIDTH/8
// PORTS
//  clk          in   1                    system clock; all state on posedge
//  rstn         in   1                    asynchronous active-low reset
//  recv_data    in   8                    byte received from spi_slave
//  recv_ready   in   1                    1-cycle strobe: recv_data valid
//  send_data    out  8                    byte shifted out during the NEXT SPI byte exchange
//  dbg_regs     in   NUM_REGS*REG_WIDTH   channel i = dbg_regs[i*REG_WIDTH +: REG_WIDTH]
//  core_clk_en  out  1                    core clock enable (registered)
//  stepping     out  1                    step counter non-zero
//  led          out  1                    debug LED
// BEHAVIOUR
//  Reset (async, rstn=0): send_data=0, core_clk_en=0, stepping=0, led=0, state=IDLE, counters=0, snapshot=0.
//  All work happens on cycles with recv_ready=1; other cycles only advance the step counter.
//  send_data updates on the recv_ready cycle and holds until the next recv_ready.
//  Commands in IDLE (send_data=0x00 unless stated):
//   0x00 NOP
//   0x01 ECHO      send_data=0x01 -> ECHO_ARG; next byte b: send_data=b -> IDLE
//   0x02 LED       led toggles
//   0x03 RUN       run_en=1
//   0x04 HALT      run_en=0; step counter cleared
//   0x05 STEP      -> STEP_ARG; next byte n: step_cnt=n; n=0 no-op; STEP while stepping reloads
//   0x06 READ      -> SEL_ARG; next byte i:
//                   i<NUM_REGS:  snapshot channel i this cycle, send_data=L, byte_cnt=L -> REPLY
//                   i>=NUM_REGS: send_data=0x00 -> IDLE
//   other          send_data=0x00, state unchanged
//  REPLY: each recv_ready sends snapshot byte byte_cnt-1 (MSB first) and decrements byte_cnt.
//   Received byte value is ignored; byte_cnt==1 -> IDLE.
//   Full READ = 2+L exchanges: cmd, index, then L data bytes (length byte leaves during the first of these).
//  core_clk_en <= run_en | (step_cnt!=0)
//   step_cnt decrements every clk cycle while non-zero and run_en=0, so STEP n gives exactly n enabled cycles.
//   RUN while stepping: counter frozen and enable stays high. HALT afterwards clears it.
//  Snapshot is registered: later dbg_regs changes do not alter the reply in flight.
//  Channel index is an 8-bit compare; widths wrap nowhere, since byte_cnt is $clog2(L+1) bits.
// CONFIGURATION
//  SPI_DBG_BREAKPOINT_EN defined: adds
//   - ports bp_pc in REG_WIDTH (core pc) and bp_hit out 1 (reset 0)
//   - command 0x08 SETBP: followed by L bytes MSB first -> bp_addr; then bp_armed=1, send_data=0x00
//   - command 0x09 CLRBP: bp_armed=0
//   When bp_armed & core_clk_en & bp_pc==bp_addr:
//    - run_en=0, step_cnt=0, bp_hit=1 the next cycle; bp_armed is kept
//    - bp_hit clears on the next RUN or STEP
//   Breakpoint wins over a same-cycle RUN/STEP.
//  SPI_DBG_BREAKPOINT_EN undefined: no ports, no logic; 0x08/0x09 are treated as unknown commands.
// TESTING (NUM_REGS=4, REG_WIDTH=64 unless noted)
//  1 ECHO 0x01,0xA5,0x00 -> send_data sequence 0x01,0xA5,0x00
//  2 READ: ch2=0x0123456789ABCDEF; bytes 0x06,0x02, then 9 dummies
//    -> send_data 0x00,0x08,01,23,45,67,89,AB,CD,EF, then 0x00; ch2 changed mid-reply is ignored
//  3 READ index 0x07 -> send_data 0x00 after index; next byte 0x02 toggles led (back in IDLE)
//  4 STEP 0x05,0x03 -> core_clk_en high exactly 3 clk cycles; STEP 0 -> never high
//  5 RUN then HALT mid-step -> core_clk_en drops the cycle after HALT; rstn low mid-READ -> all outputs 0, IDLE
//  6 (BREAKPOINT_EN) SETBP 0x1000, RUN, pc reaches 0x1000 -> core_clk_en=0, bp_hit=1; STEP 1 -> bp_hit=0

Source files
------------

// File: rtl/spi_debug_ctrl.sv
// Byte-stream debug command processor sitting between spi_slave and the core.
// Optional breakpoint unit enabled by defining SPI_DBG_BREAKPOINT_EN.
module spi_debug_ctrl #(
    parameter int NUM_REGS  = 4,
    parameter int REG_WIDTH = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    recv_data,
    input  logic                          recv_ready,
    output logic [7:0]                    send_data,
    input  logic [NUM_REGS*REG_WIDTH-1:0] dbg_regs,
`ifdef SPI_DBG_BREAKPOINT_EN
    input  logic [REG_WIDTH-1:0]          bp_pc,
    output logic                          bp_hit,
`endif
    output logic                          core_clk_en,
    output logic                          stepping,
    output logic                          led
);

    localparam int L  = REG_WIDTH / 8;
    localparam int CW = $clog2(L + 1);

    typedef enum logic [2:0] {
        IDLE, ECHO_ARG, STEP_ARG, SEL_ARG, REPLY, BP_ARG
    } state_t;

    state_t               state;
    logic                 run_en;
    logic [7:0]           step_cnt;
    logic [CW-1:0]        byte_cnt;
    logic [REG_WIDTH-1:0] snapshot;
    logic [REG_WIDTH-1:0] sel_reg;
    logic [7:0]           reply_byte;
    logic                 idx_valid;
`ifdef SPI_DBG_BREAKPOINT_EN
    logic [REG_WIDTH-1:0] bp_addr;
    logic                 bp_armed;
`endif

    // Channel mux written as a compare chain so no index can ever fall outside dbg_regs.
    always_comb begin
        sel_reg = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (recv_data == 8'(i)) sel_reg = dbg_regs[i*REG_WIDTH +: REG_WIDTH];
        end
    end

    assign idx_valid  = {1'b0, recv_data} < 9'(NUM_REGS);
    assign reply_byte = 8'(snapshot >> {byte_cnt - CW'(1), 3'b000});
    assign stepping   = step_cnt != 8'd0;

    // NOTE: every register here uses non-blocking assignment; later assignments in the
    // block intentionally override earlier defaults (e.g. breakpoint beats RUN/STEP).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            send_data   <= 8'h00;
            led         <= 1'b0;
            run_en      <= 1'b0;
            step_cnt    <= 8'd0;
            byte_cnt    <= '0;
            // NOTE: the snapshot is a plain register bank, so resetting it is cheap and
            // guarantees a defined reply even before the first READ.
            snapshot    <= '0;
            core_clk_en <= 1'b0;
`ifdef SPI_DBG_BREAKPOINT_EN
            bp_addr     <= '0;
            bp_armed    <= 1'b0;
            bp_hit      <= 1'b0;
`endif
        end else begin
            if (step_cnt != 8'd0 && !run_en) step_cnt <= step_cnt - 8'd1;

            if (recv_ready) begin
                case (state)
                    IDLE: begin
                        send_data <= 8'h00;
                        case (recv_data)
                            8'h01: begin send_data <= 8'h01; state <= ECHO_ARG; end
                            8'h02: led <= ~led;
                            8'h03: begin
                                run_en <= 1'b1;
`ifdef SPI_DBG_BREAKPOINT_EN
                                bp_hit <= 1'b0;
`endif
                            end
                            8'h04: begin run_en <= 1'b0; step_cnt <= 8'd0; end
                            8'h05: begin
                                state <= STEP_ARG;
`ifdef SPI_DBG_BREAKPOINT_EN
                                bp_hit <= 1'b0;
`endif
                            end
                            8'h06: state <= SEL_ARG;
`ifdef SPI_DBG_BREAKPOINT_EN
                            8'h08: begin byte_cnt <= CW'(L); state <= BP_ARG; end
                            8'h09: bp_armed <= 1'b0;
`endif
                            default: ;
                        endcase
                    end
                    ECHO_ARG: begin
                        send_data <= recv_data;
                        state     <= IDLE;
                    end
                    STEP_ARG: begin
                        send_data <= 8'h00;
                        step_cnt  <= recv_data;
                        state     <= IDLE;
                    end
                    SEL_ARG: begin
                        if (idx_valid) begin
                            snapshot  <= sel_reg;
                            send_data <= 8'(L);
                            byte_cnt  <= CW'(L);
                            state     <= REPLY;
                        end else begin
                            send_data <= 8'h00;
                            state     <= IDLE;
                        end
                    end
                    REPLY: begin
                        send_data <= reply_byte;
                        byte_cnt  <= byte_cnt - CW'(1);
                        if (byte_cnt == CW'(1)) state <= IDLE;
                    end
`ifdef SPI_DBG_BREAKPOINT_EN
                    BP_ARG: begin
                        send_data <= 8'h00;
                        bp_addr   <= REG_WIDTH'({bp_addr, recv_data});
                        byte_cnt  <= byte_cnt - CW'(1);
                        if (byte_cnt == CW'(1)) begin
                            bp_armed <= 1'b1;
                            state    <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end

`ifdef SPI_DBG_BREAKPOINT_EN
            if (bp_armed && core_clk_en && bp_pc == bp_addr) begin
                run_en   <= 1'b0;
                step_cnt <= 8'd0;
                bp_hit   <= 1'b1;
            end
`endif

            core_clk_en <= run_en | (step_cnt != 8'd0);
        end
    end

endmodule

// File: tb/tb_spi_debug_ctrl.sv
// Scoreboard bench for spi_debug_ctrl: expected send_data bytes are queued as each
// command byte is driven and popped when the reply appears after the exchange.
module tb_spi_debug_ctrl;

    localparam int NUM_REGS  = 4;
    localparam int REG_WIDTH = 64;

    logic                          clk = 1'b0;
    logic                          rstn = 1'b0;
    logic [7:0]                    recv_data = 8'h00;
    logic                          recv_ready = 1'b0;
    logic [7:0]                    send_data;
    logic [NUM_REGS*REG_WIDTH-1:0] dbg_regs = '0;
    logic                          core_clk_en;
    logic                          stepping;
    logic                          led;
`ifdef SPI_DBG_BREAKPOINT_EN
    logic [REG_WIDTH-1:0]          bp_pc = '0;
    logic                          bp_hit;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];
    logic       led_exp = 1'b0;

    always #5 clk = ~clk;

    spi_debug_ctrl #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .recv_data   (recv_data),
        .recv_ready  (recv_ready),
        .send_data   (send_data),
        .dbg_regs    (dbg_regs),
`ifdef SPI_DBG_BREAKPOINT_EN
        .bp_pc       (bp_pc),
        .bp_hit      (bp_hit),
`endif
        .core_clk_en (core_clk_en),
        .stepping    (stepping),
        .led         (led)
    );

    // One SPI exchange: strobe a byte, then compare send_data against the queued expectation.
    task automatic xfer(input logic [7:0] b, input logic [7:0] exp, input string name);
        logic [7:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        recv_data  = b;
        recv_ready = 1'b1;
        @(negedge clk);
        recv_ready = 1'b0;
        e = sb_q.pop_front();
        n_cmp++;
        if (send_data !== e) begin
            n_err++;
            $display("FAIL %s: send_data=%02h expected %02h", name, send_data, e);
        end
    endtask

    task automatic count_en(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (core_clk_en === 1'b1) cnt++;
        end
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({send_data, core_clk_en, stepping, led} !== 11'd0) begin
            n_err++;
            $display("FAIL reset: send_data=%02h en=%b stepping=%b led=%b expected all 0",
                     send_data, core_clk_en, stepping, led);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_echo;
        xfer(8'h01, 8'h01, "echo_cmd");
        xfer(8'hA5, 8'hA5, "echo_arg");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (send_data !== 8'hA5) begin
            n_err++;
            $display("FAIL echo_hold: send_data=%02h expected a5", send_data);
        end
        xfer(8'h00, 8'h00, "echo_nop");
        xfer(8'h7F, 8'h00, "unknown_cmd");
        xfer(8'h01, 8'h01, "echo_after_unknown");
        xfer(8'h3C, 8'h3C, "echo_arg2");
    endtask

    task automatic test_read;
        logic [63:0] ch2 = 64'h0123456789ABCDEF;
        dbg_regs[2*64 +: 64] = ch2;
        xfer(8'h06, 8'h00, "read_cmd");
        xfer(8'h02, 8'h08, "read_len");
        for (int k = 0; k < 8; k++) begin
            xfer(8'hFF, 8'(ch2 >> (56 - 8*k)), $sformatf("read_byte%0d", k));
            if (k == 0) dbg_regs[2*64 +: 64] = 64'hDEADBEEFCAFEF00D;
        end
        xfer(8'h00, 8'h00, "read_back_idle");
    endtask

    task automatic test_bad_index;
        xfer(8'h06, 8'h00, "badidx_cmd");
        xfer(8'h07, 8'h00, "badidx_idx");
        xfer(8'h02, 8'h00, "badidx_led");
        led_exp = ~led_exp;
        n_cmp++;
        if (led !== led_exp) begin
            n_err++;
            $display("FAIL badidx_led_state: led=%b expected %b", led, led_exp);
        end
    endtask

    task automatic test_step;
        int cnt;
        xfer(8'h05, 8'h00, "step_cmd");
        xfer(8'h03, 8'h00, "step_arg");
        count_en(20, cnt);
        n_cmp++;
        if (cnt != 3) begin
            n_err++;
            $display("FAIL step3_cycles: enabled=%0d expected 3", cnt);
        end
        n_cmp++;
        if (stepping !== 1'b0) begin
            n_err++;
            $display("FAIL step3_done: stepping=%b expected 0", stepping);
        end
        xfer(8'h05, 8'h00, "step0_cmd");
        xfer(8'h00, 8'h00, "step0_arg");
        count_en(10, cnt);
        n_cmp++;
        if (cnt != 0) begin
            n_err++;
            $display("FAIL step0_cycles: enabled=%0d expected 0", cnt);
        end
    endtask

    task automatic test_run_halt;
        int cnt;
        xfer(8'h05, 8'h00, "rh_step_cmd");
        xfer(8'h0A, 8'h00, "rh_step_arg");
        repeat (2) @(negedge clk);
        xfer(8'h03, 8'h00, "rh_run");
        count_en(12, cnt);
        n_cmp++;
        if (cnt != 12 || stepping !== 1'b1) begin
            n_err++;
            $display("FAIL run_frozen: enabled=%0d stepping=%b expected 12 and 1", cnt, stepping);
        end
        xfer(8'h04, 8'h00, "rh_halt");
        n_cmp++;
        if (stepping !== 1'b0) begin
            n_err++;
            $display("FAIL halt_clears: stepping=%b expected 0", stepping);
        end
        @(negedge clk);
        n_cmp++;
        if (core_clk_en !== 1'b0) begin
            n_err++;
            $display("FAIL halt_en: core_clk_en=%b expected 0", core_clk_en);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [63:0] ch1 = 64'hA1B2C3D4E5F60718;
        dbg_regs[1*64 +: 64] = ch1;
        xfer(8'h03, 8'h00, "rm_run");
        xfer(8'h06, 8'h00, "rm_read_cmd");
        xfer(8'h01, 8'h08, "rm_read_len");
        xfer(8'h00, ch1[63:56], "rm_read_b0");
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({send_data, core_clk_en, stepping, led} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_mid_read: send_data=%02h en=%b stepping=%b led=%b expected all 0",
                     send_data, core_clk_en, stepping, led);
        end
        led_exp = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        xfer(8'h01, 8'h01, "rm_echo_cmd");
        xfer(8'h5A, 8'h5A, "rm_echo_arg");
        repeat (2) @(negedge clk);
        n_cmp++;
        if (core_clk_en !== 1'b0) begin
            n_err++;
            $display("FAIL rm_run_cleared: core_clk_en=%b expected 0", core_clk_en);
        end
    endtask

`ifdef SPI_DBG_BREAKPOINT_EN
    task automatic test_breakpoint;
        logic [63:0] addr = 64'h1000;
        xfer(8'h08, 8'h00, "bp_set_cmd");
        for (int k = 0; k < 8; k++) xfer(8'(addr >> (56 - 8*k)), 8'h00, "bp_set_byte");
        xfer(8'h03, 8'h00, "bp_run");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (core_clk_en !== 1'b1 || bp_hit !== 1'b0) begin
            n_err++;
            $display("FAIL bp_running: en=%b bp_hit=%b expected 1 and 0", core_clk_en, bp_hit);
        end
        bp_pc = 64'h1000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (core_clk_en !== 1'b0 || bp_hit !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hit: en=%b bp_hit=%b expected 0 and 1", core_clk_en, bp_hit);
        end
        xfer(8'h05, 8'h00, "bp_step_cmd");
        n_cmp++;
        if (bp_hit !== 1'b0) begin
            n_err++;
            $display("FAIL bp_clear: bp_hit=%b expected 0", bp_hit);
        end
        xfer(8'h01, 8'h00, "bp_step_arg");
    endtask
`endif

    initial begin
        dbg_regs[0 +: 64]    = 64'h0000000000000400;
        dbg_regs[3*64 +: 64] = 64'h5555AAAA5555AAAA;
        test_reset();
        test_echo();
        test_read();
        test_bad_index();
        test_step();
        test_run_halt();
        test_reset_mid_read();
`ifdef SPI_DBG_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
